reg_file_param: RTL
===================

// Module: reg_file_param
// PURPOSE
// - Parametrised successor of the RV32IM pipeline's general-purpose register file.
// - Adds N combinational read ports with optional write-through bypass and a hardwired-zero x0.
// - Generates the random register internally with a 16-bit LFSR that produces float32 values.
// - Adds a valid/ready register-dump sequencer for FPGA debug, alongside the existing debug/LCD taps.
// PARAMETERS
// DATA_W     32       register width (must be 32 when RAND_EN=1)
// ADDR_W     5        address width; depth = 2**ADDR_W
// NUM_RD     2        number of read ports
// BYPASS     1        1: a read of the register being written returns IN in the same cycle
// ZERO_R0    1        1: x0 reads 0 and ignores writes
// RAND_EN    1        1: enable the random register
// RAND_REG   31       index of the random register
// RAND_EXP   8'd130   float32 exponent field of the random value
// LFSR_SEED  16'hACE1 LFSR reset value (must be non-zero)
// LCD_REGS   6        number of registers on the LCD tap, x0 upward
// LCD_BITS   8        LSBs taken from each LCD register
// PORTS
// CLK            in   1                 clock, rising edge
// RESET          in   1                 asynchronous, active-high
// WRITE          in   1                 write enable
// INADDRESS      in   ADDR_W            write address
// IN             in   DATA_W            write data
// RD_ADDR        in   NUM_RD*ADDR_W     packed read addresses; port k = [k*ADDR_W +: ADDR_W]
// RD_DATA        out  NUM_RD*DATA_W     packed read data, combinational
// DEBUG_ADDR     in   ADDR_W            debug read address
// DEBUG_DATA     out  DATA_W            REGISTERS[DEBUG_ADDR], no bypass
// DEBUG_DATA_LCD out  LCD_REGS*LCD_BITS {R[LCD_REGS-1][LCD_BITS-1:0], ..., R[0][LCD_BITS-1:0]}
// DUMP_START     in   1                 pulse: start a full register dump
// DUMP_READY     in   1                 consumer ready
// DUMP_VALID     out  1                 dump beat valid
// DUMP_ADDR      out  ADDR_W            index of the current beat
// DUMP_DATA      out  DATA_W            contents of the current beat
// DUMP_BUSY      out  1                 dump in progress
// DUMP_DONE      out  1                 one-cycle pulse after the last beat is accepted
// BEHAVIOUR
// - Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
// - Reset values: all registers 0; LFSR = LFSR_SEED; dump FSM in IDLE.
//   - DUMP_VALID, DUMP_BUSY and DUMP_DONE are 0; DUMP_ADDR is 0.
//   - RD_DATA, DEBUG_DATA and DEBUG_DATA_LCD therefore read 0.
// - Write: on a rising edge with WRITE=1, R[INADDRESS] <= IN.
//   - With ZERO_R0=1, a write to x0 is dropped.
// - Read: RD_DATA[k] = R[RD_ADDR[k]], with zero latency.
//   - ZERO_R0=1: address 0 returns 0.
//   - BYPASS=1 and WRITE=1 and address == INADDRESS (non-zero): returns IN.
// - LFSR: Fibonacci, taps 16,14,13,11; shifts on every clock edge outside reset.
// - Random register (RAND_EN=1): each edge, R[RAND_REG] <= {lfsr[12], RAND_EXP, lfsr[11:0], 11'b0}.
//   - This uses the pre-shift LFSR value.
//   - A same-edge architectural WRITE to RAND_REG wins; the random update resumes next edge.
// - Dump FSM:
//   - IDLE -> DUMP on DUMP_START; DUMP_ADDR is set to 0.
//   - In DUMP, DUMP_VALID=1, DUMP_BUSY=1, and DUMP_DATA = R[DUMP_ADDR] (live value, no bypass).
//   - Each beat with VALID&READY increments DUMP_ADDR.
//   - A handshake at address 2**ADDR_W-1 moves to DONE.
//   - DONE lasts one cycle with DUMP_DONE=1, VALID=0, BUSY=1, then returns to IDLE.
//   - DUMP_START is ignored outside IDLE.
//   - With READY=0, ADDR holds; DATA may change only if the register itself is written.
// - Asynchronous RESET mid-dump: immediate IDLE; VALID and DONE drop with no completion pulse.
// TESTING
// T1 Reset: assert RESET with no clock edge -> all RD_DATA=0, DUMP_VALID=0; release -> LFSR=16'hACE1.
// T2 x0: write x0=32'hFFFF_FFFF, then read x0 -> 0; write x5=32'h1234_5678 -> reads 32'h1234_5678 next cycle.
// T3 Bypass: WRITE=1, INADDRESS=7, IN=32'hDEAD_BEEF, both RD_ADDR=7 -> both RD_DATA=32'hDEAD_BEEF the same cycle.
// T4 Random: first edge after reset -> R[31]={lfsr[12],8'd130,lfsr[11:0],11'b0} from 16'hACE1.
//    Check against the golden LFSR for 100 cycles; a write to x31 on one edge is visible for exactly one cycle.
// T5 Dump: fill x1..x30 with i*3, pulse DUMP_START, hold READY=1 -> 32 beats, addresses 0..31 in order.
//    Data matches; DUMP_DONE=1 exactly one cycle after beat 31. Repeat with READY toggled every cycle -> no beat lost or repeated.
// T6 Reset mid-dump: assert RESET at beat 10 -> VALID=0 immediately, no DUMP_DONE, all registers 0.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised general-purpose register file with multiple read ports, an
// LFSR-driven random register, debug/LCD taps and a valid/ready dump sequencer.
module reg_file_param #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 5,
    parameter int          NUM_RD    = 2,
    parameter bit          BYPASS    = 1'b1,
    parameter bit          ZERO_R0   = 1'b1,
    parameter bit          RAND_EN   = 1'b1,
    parameter int          RAND_REG  = 31,
    parameter logic [7:0]  RAND_EXP  = 8'd130,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          LCD_REGS  = 6,
    parameter int          LCD_BITS  = 8
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         WRITE,
    input  logic [ADDR_W-1:0]            INADDRESS,
    input  logic [DATA_W-1:0]            IN,
    input  logic [NUM_RD*ADDR_W-1:0]     RD_ADDR,
    output logic [NUM_RD*DATA_W-1:0]     RD_DATA,
    input  logic [ADDR_W-1:0]            DEBUG_ADDR,
    output logic [DATA_W-1:0]            DEBUG_DATA,
    output logic [LCD_REGS*LCD_BITS-1:0] DEBUG_DATA_LCD,
    input  logic                         DUMP_START,
    input  logic                         DUMP_READY,
    output logic                         DUMP_VALID,
    output logic [ADDR_W-1:0]            DUMP_ADDR,
    output logic [DATA_W-1:0]            DUMP_DATA,
    output logic                         DUMP_BUSY,
    output logic                         DUMP_DONE
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] RAND_IDX = ADDR_W'(RAND_REG);

    typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE} dump_state_t;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nx;
    logic [DATA_W-1:0] rand_val;
    logic              wr_ok;
    dump_state_t       state, state_nx;
    logic [ADDR_W-1:0] dump_addr, dump_addr_nx;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
    assign lfsr_nx  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign rand_val = DATA_W'({lfsr[12], RAND_EXP, lfsr[11:0], 11'b0});
    assign wr_ok    = WRITE && !(ZERO_R0 && (INADDRESS == '0));

    // Architectural write is placed last so it overrides the random update.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs <= '{default: '0};
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_nx;
            if (RAND_EN)
                regs[RAND_IDX] <= rand_val;
            if (wr_ok)
                regs[INADDRESS] <= IN;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        assign addr = RD_ADDR[k*ADDR_W +: ADDR_W];
        always_comb begin
            data = regs[addr];
            if (ZERO_R0 && (addr == '0))
                data = '0;
            else if (BYPASS && WRITE && (addr == INADDRESS))
                data = IN;
        end
        assign RD_DATA[k*DATA_W +: DATA_W] = data;
    end

    assign DEBUG_DATA = regs[DEBUG_ADDR];

    for (genvar i = 0; i < LCD_REGS; i++) begin : g_lcd
        assign DEBUG_DATA_LCD[i*LCD_BITS +: LCD_BITS] = regs[i][LCD_BITS-1:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            dump_addr <= '0;
        end else begin
            state     <= state_nx;
            dump_addr <= dump_addr_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        dump_addr_nx = dump_addr;
        case (state)
            S_IDLE: begin
                if (DUMP_START) begin
                    state_nx     = S_DUMP;
                    dump_addr_nx = '0;
                end
            end
            S_DUMP: begin
                if (DUMP_READY) begin
                    dump_addr_nx = dump_addr + 1'b1;
                    if (dump_addr == '1)
                        state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        DUMP_VALID = 1'b0;
        DUMP_BUSY  = 1'b0;
        DUMP_DONE  = 1'b0;
        DUMP_DATA  = '0;
        case (state)
            S_DUMP: begin
                DUMP_VALID = 1'b1;
                DUMP_BUSY  = 1'b1;
                DUMP_DATA  = regs[dump_addr];
            end
            S_DONE: begin
                DUMP_BUSY = 1'b1;
                DUMP_DONE = 1'b1;
            end
            default: ;
        endcase
    end

    assign DUMP_ADDR = dump_addr;

endmodule
